led_panel_scan_ctrl: RTL and testbench

//  Scan controller for the 32x16 RGB LED panel (1/8 scan, two half-panels in parallel).

---
 rtl/led_panel_scan_ctrl.sv | 176 +++++++++++++++++
 tb/tb_led_panel_scan_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_panel_scan_ctrl.sv
// Scan controller for a 1/8-scan RGB LED panel: shifts one BCM bit-plane per row,
// latches it, then holds OE low for a binary-weighted on-time.
module led_panel_scan_ctrl #(
    parameter int unsigned COLS           = 32,
    parameter int unsigned ROW_ADDR_W     = 3,
    parameter int unsigned BCM_BITS       = 4,
    parameter int unsigned CLK_DIV        = 4,
    parameter int unsigned BASE_ON_CYCLES = 64
) (
    input  logic                                i_sysclk,
    input  logic                                i_sysreset,
    input  logic                                i_enable,
    output logic [ROW_ADDR_W+$clog2(COLS)-1:0]  o_fb_addr,
    input  logic [6*BCM_BITS-1:0]               i_fb_rdata,
    output logic [2:0]                          o_led_rgb1,
    output logic [2:0]                          o_led_rgb2,
    output logic [ROW_ADDR_W-1:0]               o_led_abc,
    output logic                                o_led_clk,
    output logic                                o_led_latch,
    output logic                                o_led_oe,
    output logic                                o_frame_done
);
    localparam int unsigned COL_W = $clog2(COLS);
    localparam int unsigned PL_W  = (BCM_BITS > 1) ? $clog2(BCM_BITS) : 1;
    localparam int unsigned OE_W  = $clog2(BASE_ON_CYCLES << (BCM_BITS - 1)) + 1;
    localparam int unsigned SH_W  = $clog2(2 * CLK_DIV);
    localparam int unsigned CNT_W = (OE_W > SH_W) ? OE_W : SH_W;
    localparam int unsigned AW    = ROW_ADDR_W + COL_W;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LATCH, S_DISPLAY} state_t;

    state_t                r_state, w_state;
    logic [CNT_W-1:0]      r_cnt, w_cnt;
    logic [COL_W-1:0]      r_col, w_col;
    logic [ROW_ADDR_W-1:0] r_row, w_row;
    logic [PL_W-1:0]       r_plane, w_plane;
    logic [AW-1:0]         r_fb_addr, w_fb_addr;
    logic [2:0]            r_rgb1, w_rgb1;
    logic [2:0]            r_rgb2, w_rgb2;
    logic [ROW_ADDR_W-1:0] r_abc, w_abc;
    logic                  r_clk, w_clk;
    logic                  r_latch, w_latch;
    logic                  r_oe, w_oe;
    logic                  r_fd, w_fd;
    logic [CNT_W-1:0]      w_on_last;
    logic [BCM_BITS-1:0]   w_chan [6];

    // Channel order in the read word: topR, topG, topB, botR, botG, botB
    for (genvar k = 0; k < 6; k++) begin : g_chan
        assign w_chan[k] = i_fb_rdata[(6-k)*BCM_BITS-1 -: BCM_BITS];
    end

    assign w_on_last = (CNT_W'(BASE_ON_CYCLES) << r_plane) - CNT_W'(1);

    always_comb begin
        w_state   = r_state;
        w_cnt     = r_cnt;
        w_col     = r_col;
        w_row     = r_row;
        w_plane   = r_plane;
        w_fd      = 1'b0;
        w_fb_addr = r_fb_addr;
        w_abc     = r_abc;
        w_rgb1    = r_rgb1;
        w_rgb2    = r_rgb2;
        w_clk     = 1'b0;
        w_latch   = 1'b0;
        w_oe      = 1'b1;

        case (r_state)
            S_IDLE: begin
                if (i_enable) begin
                    w_state = S_SHIFT;
                    w_cnt   = '0;
                    w_col   = '0;
                end
            end
            S_SHIFT: begin
                if (r_cnt == CNT_W'(2 * CLK_DIV - 1)) begin
                    w_cnt = '0;
                    if (r_col == COL_W'(COLS - 1)) begin
                        w_state = S_LATCH;
                        w_col   = '0;
                    end else begin
                        w_col = r_col + COL_W'(1);
                    end
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            S_LATCH: begin
                if (r_cnt == CNT_W'(CLK_DIV - 1)) begin
                    w_state = S_DISPLAY;
                    w_cnt   = '0;
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            S_DISPLAY: begin
                // Plane boundary: the only point where enable is honoured mid-scan
                if (r_cnt == w_on_last) begin
                    w_cnt   = '0;
                    w_state = i_enable ? S_SHIFT : S_IDLE;
                    if (r_plane == PL_W'(BCM_BITS - 1)) begin
                        w_plane = '0;
                        w_row   = r_row + ROW_ADDR_W'(1);
                        w_fd    = &r_row;
                    end else begin
                        w_plane = r_plane + PL_W'(1);
                    end
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            default: w_state = S_IDLE;
        endcase

        // Output registers track the state being entered so they align with it
        w_clk   = (w_state == S_SHIFT) && (w_cnt >= CNT_W'(CLK_DIV));
        w_latch = (w_state == S_LATCH);
        w_oe    = (w_state != S_DISPLAY);
        if (w_state == S_SHIFT) begin
            w_fb_addr = {w_row, w_col};
        end
        if (w_state == S_LATCH) begin
            w_abc = w_row;
        end
        // Read data for the column is valid in its second low cycle
        if ((r_state == S_SHIFT) && (r_cnt == CNT_W'(1))) begin
            w_rgb1 = {w_chan[0][r_plane], w_chan[1][r_plane], w_chan[2][r_plane]};
            w_rgb2 = {w_chan[3][r_plane], w_chan[4][r_plane], w_chan[5][r_plane]};
        end
    end

    always_ff @(posedge i_sysclk) begin
        if (i_sysreset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_col     <= '0;
            r_row     <= '0;
            r_plane   <= '0;
            r_fb_addr <= '0;
            r_rgb1    <= '0;
            r_rgb2    <= '0;
            r_abc     <= '0;
            r_clk     <= 1'b0;
            r_latch   <= 1'b0;
            r_oe      <= 1'b1;
            r_fd      <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_cnt     <= w_cnt;
            r_col     <= w_col;
            r_row     <= w_row;
            r_plane   <= w_plane;
            r_fb_addr <= w_fb_addr;
            r_rgb1    <= w_rgb1;
            r_rgb2    <= w_rgb2;
            r_abc     <= w_abc;
            r_clk     <= w_clk;
            r_latch   <= w_latch;
            r_oe      <= w_oe;
            r_fd      <= w_fd;
        end
    end

    assign o_fb_addr    = r_fb_addr;
    assign o_led_rgb1   = r_rgb1;
    assign o_led_rgb2   = r_rgb2;
    assign o_led_abc    = r_abc;
    assign o_led_clk    = r_clk;
    assign o_led_latch  = r_latch;
    assign o_led_oe     = r_oe;
    assign o_frame_done = r_fd;

endmodule

// File: tb/tb_led_panel_scan_ctrl.sv
// Bench for led_panel_scan_ctrl: random framebuffer contents, expected panel waveform
// derived per cycle from the scan timing rules (shift, latch, binary-weighted on-time).
module tb_led_panel_scan_ctrl;
    localparam int unsigned COLS       = 32;
    localparam int unsigned ROW_ADDR_W = 3;
    localparam int unsigned BCM_BITS   = 4;
    localparam int unsigned CLK_DIV    = 4;
    localparam int unsigned BASE_ON    = 64;
    localparam int unsigned ROWS       = 1 << ROW_ADDR_W;
    localparam int unsigned AW         = ROW_ADDR_W + 5;
    localparam int unsigned SHIFT_CYC  = COLS * 2 * CLK_DIV;

    logic                  clk      = 1'b0;
    logic                  sysreset = 1'b1;
    logic                  enable   = 1'b0;
    logic [AW-1:0]         fb_addr;
    logic [6*BCM_BITS-1:0] fb_rdata;
    logic [2:0]            rgb1, rgb2;
    logic [ROW_ADDR_W-1:0] abc;
    logic                  led_clk, latch, oe, fd;

    logic [23:0]  mem [256];
    int           checks   = 0;
    int           failures = 0;
    int unsigned  cyc      = 0;
    int           m_row    = 0;
    int           m_plane  = 0;
    bit           pending_fd = 1'b0;
    int unsigned  fd_cyc [$];
    logic [2:0]   last_rgb1 [4];
    logic [2:0]   last_rgb2 [4];

    led_panel_scan_ctrl #(
        .COLS(COLS), .ROW_ADDR_W(ROW_ADDR_W), .BCM_BITS(BCM_BITS),
        .CLK_DIV(CLK_DIV), .BASE_ON_CYCLES(BASE_ON)
    ) dut (
        .i_sysclk(clk), .i_sysreset(sysreset), .i_enable(enable),
        .o_fb_addr(fb_addr), .i_fb_rdata(fb_rdata),
        .o_led_rgb1(rgb1), .o_led_rgb2(rgb2), .o_led_abc(abc),
        .o_led_clk(led_clk), .o_led_latch(latch), .o_led_oe(oe), .o_frame_done(fd)
    );

    always #5 clk = ~clk;

    // Registered framebuffer: data valid one cycle after the address
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        fb_rdata <= mem[fb_addr];
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    function automatic logic [2:0] exp_rgb(input logic [23:0] px, input logic [1:0] p, input bit top);
        logic [3:0] r, g, b;
        {r, g, b} = top ? px[23:12] : px[11:0];
        return {r[p], g[p], b[p]};
    endfunction

    // Checks n consecutive planes starting at the next cycle; enable drops at t==stop_at of the last one
    task automatic check_planes(input int n, input int stop_at);
        int on_len, total, col, ph, oe_low, rises;
        logic prev_clk;
        logic [3:0] e_ctl, a_ctl;
        logic [AW-1:0] e_addr;
        logic [5:0] e_rgb;
        logic [23:0] px;
        for (int k = 0; k < n; k++) begin
            on_len   = BASE_ON << m_plane;
            total    = SHIFT_CYC + CLK_DIV + on_len;
            oe_low   = 0;
            rises    = 0;
            prev_clk = 1'b0;
            for (int t = 0; t < total; t++) begin
                @(negedge clk);
                if (k == n - 1 && t == stop_at) enable = 1'b0;
                col = t / (2 * CLK_DIV);
                ph  = t % (2 * CLK_DIV);
                e_ctl[0] = (t == 0) && pending_fd;
                if (t < SHIFT_CYC)                 e_ctl[3:1] = {ph >= CLK_DIV, 1'b0, 1'b1};
                else if (t < SHIFT_CYC + CLK_DIV)  e_ctl[3:1] = 3'b011;
                else                               e_ctl[3:1] = 3'b000;
                a_ctl = {led_clk, latch, oe, fd};
                checks++;
                if (a_ctl !== e_ctl) begin
                    failures++;
                    $display("FAIL ctl row=%0d plane=%0d t=%0d: {clk,latch,oe,done} got %b expected %b",
                             m_row, m_plane, t, a_ctl, e_ctl);
                end
                if (fd === 1'b1) fd_cyc.push_back(cyc);
                if (oe === 1'b0) oe_low++;
                if (led_clk === 1'b1 && prev_clk === 1'b0) rises++;
                prev_clk = led_clk;
                if (t < SHIFT_CYC && ph == 0) begin
                    e_addr = AW'(m_row * COLS + col);
                    checks++;
                    if (fb_addr !== e_addr) begin
                        failures++;
                        $display("FAIL fb_addr row=%0d plane=%0d col=%0d: got %h expected %h",
                                 m_row, m_plane, col, fb_addr, e_addr);
                    end
                end
                if (t < SHIFT_CYC && ph >= CLK_DIV) begin
                    px    = mem[m_row * COLS + col];
                    e_rgb = {exp_rgb(px, 2'(m_plane), 1'b1), exp_rgb(px, 2'(m_plane), 1'b0)};
                    checks++;
                    if ({rgb1, rgb2} !== e_rgb) begin
                        failures++;
                        $display("FAIL rgb row=%0d plane=%0d col=%0d: {rgb1,rgb2} got %b expected %b",
                                 m_row, m_plane, col, {rgb1, rgb2}, e_rgb);
                    end
                    last_rgb1[m_plane] = rgb1;
                    last_rgb2[m_plane] = rgb2;
                end
                if (t >= SHIFT_CYC) begin
                    checks++;
                    if (abc !== ROW_ADDR_W'(m_row)) begin
                        failures++;
                        $display("FAIL abc row=%0d plane=%0d t=%0d: got %0d expected %0d",
                                 m_row, m_plane, t, abc, m_row);
                    end
                end
                if (failures > 40) return;
            end
            checks++;
            if (oe_low != on_len) begin
                failures++;
                $display("FAIL oe_on_time row=%0d plane=%0d: got %0d expected %0d", m_row, m_plane, oe_low, on_len);
            end
            checks++;
            if (rises != COLS) begin
                failures++;
                $display("FAIL clk_edges row=%0d plane=%0d: got %0d expected %0d", m_row, m_plane, rises, COLS);
            end
            pending_fd = (m_row == ROWS - 1) && (m_plane == BCM_BITS - 1);
            if (m_plane == BCM_BITS - 1) begin
                m_plane = 0;
                m_row   = (m_row + 1) % ROWS;
            end else begin
                m_plane++;
            end
        end
    endtask

    task automatic test_reset();
        int falls;
        logic prev_oe;
        sysreset = 1'b1;
        enable   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (oe !== 1'b1)    begin failures++; $display("FAIL rst_oe: got %b expected 1", oe); end
        checks++; if (led_clk !== 1'b0) begin failures++; $display("FAIL rst_clk: got %b expected 0", led_clk); end
        checks++; if (latch !== 1'b0) begin failures++; $display("FAIL rst_latch: got %b expected 0", latch); end
        checks++; if (abc !== '0)     begin failures++; $display("FAIL rst_abc: got %0d expected 0", abc); end
        checks++; if (fb_addr !== '0) begin failures++; $display("FAIL rst_fb_addr: got %h expected 0", fb_addr); end
        checks++; if ({rgb1, rgb2} !== 6'b0) begin failures++; $display("FAIL rst_rgb: got %b expected 0", {rgb1, rgb2}); end
        checks++; if (fd !== 1'b0)    begin failures++; $display("FAIL rst_done: got %b expected 0", fd); end
        sysreset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if ({oe, led_clk, latch, fb_addr} !== {3'b100, AW'(0)}) begin
                failures++;
                $display("FAIL idle_hold: {oe,clk,latch,addr} got %b expected %b", {oe, led_clk, latch, fb_addr}, {3'b100, AW'(0)});
            end
        end
        // Run into the display phase of row 1 (fifth OE-low window), then reset
        enable  = 1'b1;
        falls   = 0;
        prev_oe = 1'b1;
        for (int i = 0; i < 4000 && falls < 5; i++) begin
            @(negedge clk);
            if (prev_oe === 1'b1 && oe === 1'b0) falls++;
            prev_oe = oe;
        end
        checks++;
        if (falls != 5) begin failures++; $display("FAIL reach_display: got %0d OE windows expected 5", falls); end
        sysreset = 1'b1;
        enable   = 1'b0;
        @(negedge clk);
        checks++; if (oe !== 1'b1)    begin failures++; $display("FAIL mid_rst_oe: got %b expected 1", oe); end
        checks++; if (led_clk !== 1'b0) begin failures++; $display("FAIL mid_rst_clk: got %b expected 0", led_clk); end
        checks++; if (latch !== 1'b0) begin failures++; $display("FAIL mid_rst_latch: got %b expected 0", latch); end
        checks++; if (abc !== '0)     begin failures++; $display("FAIL mid_rst_abc: got %0d expected 0", abc); end
        checks++; if (fb_addr !== '0) begin failures++; $display("FAIL mid_rst_fb_addr: got %h expected 0", fb_addr); end
        sysreset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if ({oe, led_clk, latch, abc} !== {3'b100, ROW_ADDR_W'(0)}) begin
                failures++;
                $display("FAIL post_rst_idle: {oe,clk,latch,abc} got %b expected %b", {oe, led_clk, latch, abc}, {3'b100, ROW_ADDR_W'(0)});
            end
        end
        m_row      = 0;
        m_plane    = 0;
        pending_fd = 1'b0;
    endtask

    task automatic test_shift_timing();
        for (int i = 0; i < 256; i++) mem[i] = 24'($urandom());
        enable = 1'b1;
        check_planes(BCM_BITS, -1);
    endtask

    task automatic test_wrap();
        int exp_period, period;
        exp_period = 0;
        for (int p = 0; p < BCM_BITS; p++) exp_period += SHIFT_CYC + CLK_DIV + (BASE_ON << p);
        exp_period *= ROWS;
        fd_cyc.delete();
        check_planes((ROWS - 1) * BCM_BITS, -1);
        check_planes(ROWS * BCM_BITS, -1);
        check_planes(1, -1);
        checks++;
        if (fd_cyc.size() != 2) begin
            failures++;
            $display("FAIL frame_done_count: got %0d expected 2", fd_cyc.size());
        end
        period = (fd_cyc.size() >= 2) ? int'(fd_cyc[1] - fd_cyc[0]) : 0;
        checks++;
        if (period != exp_period) begin
            failures++;
            $display("FAIL frame_period: got %0d expected %0d", period, exp_period);
        end
    endtask

    task automatic test_colour();
        logic [2:0] e2;
        for (int i = 0; i < 256; i++) mem[i] = {12'hFFF, 12'h800};
        check_planes(BCM_BITS - 1, -1);
        check_planes(BCM_BITS, -1);
        for (int p = 0; p < BCM_BITS; p++) begin
            e2 = (p == BCM_BITS - 1) ? 3'b100 : 3'b000;
            checks++;
            if (last_rgb1[p] !== 3'b111) begin
                failures++;
                $display("FAIL colour_top plane=%0d: got %b expected 111", p, last_rgb1[p]);
            end
            checks++;
            if (last_rgb2[p] !== e2) begin
                failures++;
                $display("FAIL colour_bot plane=%0d: got %b expected %b", p, last_rgb2[p], e2);
            end
        end
    endtask

    task automatic test_stop();
        int stop_at;
        logic [ROW_ADDR_W-1:0] held_row;
        for (int i = 0; i < 256; i++) mem[i] = 24'($urandom());
        check_planes(2, -1);
        stop_at  = int'($urandom_range(16, SHIFT_CYC - 16));
        held_row = ROW_ADDR_W'(m_row);
        check_planes(1, stop_at);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            checks++;
            if ({oe, led_clk, latch, fd, abc} !== {3'b100, (i == 0) && pending_fd, held_row}) begin
                failures++;
                $display("FAIL stop_idle cycle=%0d: {oe,clk,latch,done,abc} got %b expected %b",
                         i, {oe, led_clk, latch, fd, abc}, {3'b100, (i == 0) && pending_fd, held_row});
            end
        end
        pending_fd = 1'b0;
        enable     = 1'b1;
        check_planes(1, -1);
        enable = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 24'($urandom());
        test_reset();
        test_shift_timing();
        test_wrap();
        test_colour();
        test_stop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
